// File: rtl/bw_io_ddr_rptr_pipe_if.sv
// ---------------------------------------------------------------------------
// bw_io_ddr_rptr_pipe_if
//   Bundles the channel bus of the DDR repeater pipeline.
//   master : upstream/controller side (drives din, vld_in, din_par, hold,
//            flush, byp; observes dout, vld_out, pipe_rdy, perr)
//   slave  : repeater side (bw_io_ddr_rptr_pipe)
//   Signals:
//     din      [NCH*W]  channel data, channel c = din[c*W +: W]
//     vld_in   [NCH]    per-channel valid
//     din_par  [NCH]    per-channel even parity of din
//     hold              freeze whole pipeline
//     flush             clear valids, fill counter, parity errors
//     byp               static combinational bypass select
//     dout     [NCH*W]  repeated data
//     vld_out  [NCH]    repeated valid
//     pipe_rdy          pipeline primed since last reset/flush
//     perr     [NCH]    sticky parity error flags
// ---------------------------------------------------------------------------
interface bw_io_ddr_rptr_pipe_if #(
   parameter int NCH = 8,
   parameter int W   = 8
);
   logic [NCH*W-1:0] din;
   logic [NCH-1:0]   vld_in;
   logic [NCH-1:0]   din_par;
   logic             hold;
   logic             flush;
   logic             byp;
   logic [NCH*W-1:0] dout;
   logic [NCH-1:0]   vld_out;
   logic             pipe_rdy;
   logic [NCH-1:0]   perr;

   modport master (
      output din, vld_in, din_par, hold, flush, byp,
      input  dout, vld_out, pipe_rdy, perr
   );

   modport slave (
      input  din, vld_in, din_par, hold, flush, byp,
      output dout, vld_out, pipe_rdy, perr
   );
endinterface

// File: rtl/bw_io_ddr_rptr_pipe.sv
// ---------------------------------------------------------------------------
// bw_io_ddr_rptr_pipe
//   Retimed DDR pad-ring repeater: NCH independent W-bit channels, each
//   carried through a STAGES-deep flopped pipeline with per-channel valid
//   tracking, global hold/flush and a static combinational bypass.
//
//   Ports:
//     clk   core clock, posedge
//     rst   asynchronous active-high reset
//     bus   bw_io_ddr_rptr_pipe_if.slave (see interface header)
//
//   Optional feature macro: BW_IO_DDR_RPTR_PAR_EN
//     defined   : din_par travels with the data; a valid output beat whose
//                 data/parity disagree sets a sticky perr bit one cycle later.
//     undefined : no parity flops, din_par ignored, perr tied to 0.
// ---------------------------------------------------------------------------
module bw_io_ddr_rptr_pipe #(
   parameter int NCH    = 8,
   parameter int W      = 8,
   parameter int STAGES = 2,
   parameter int CW     = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   bw_io_ddr_rptr_pipe_if.slave     bus
);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------------
   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("bw_io_ddr_rptr_pipe: STAGES=%0d outside legal range 1..4", STAGES);
   end

   if ((2 ** CW) <= STAGES) begin : g_bad_cw
      $error("bw_io_ddr_rptr_pipe: CW=%0d too narrow for STAGES=%0d", CW, STAGES);
   end

   localparam int            LAST = STAGES - 1;
   localparam logic [CW-1:0] FULL = CW'(STAGES);

   // ------------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------------
   logic [W-1:0]     d_q [STAGES][NCH];
   logic [NCH-1:0]   v_q [STAGES];
   logic [CW-1:0]    cnt_q;
   logic             rdy_q;
   logic [NCH*W-1:0] dout_pipe;

   // Stage registers. Valid bits always shift; data only moves when the
   // bit ahead of it is valid, so idle channels do not toggle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            v_q[k] <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
               d_q[k][c] <= '0;
            end
         end
      end else if (bus.flush) begin
         // flush wins over hold; data registers keep their contents
         for (int unsigned k = 0; k < STAGES; k++) begin
            v_q[k] <= '0;
         end
      end else if (!bus.hold) begin
         v_q[0] <= bus.vld_in;
         for (int unsigned k = 1; k < STAGES; k++) begin
            v_q[k] <= v_q[k-1];
         end
         for (int unsigned c = 0; c < NCH; c++) begin
            if (bus.vld_in[c]) begin
               d_q[0][c] <= bus.din[c*W +: W];
            end
         end
         for (int unsigned k = 1; k < STAGES; k++) begin
            for (int unsigned c = 0; c < NCH; c++) begin
               if (v_q[k-1][c]) begin
                  d_q[k][c] <= d_q[k-1][c];
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Fill counter and ready flag
   // ------------------------------------------------------------------------
   // rdy_q samples the counter after it has saturated, so it rises one
   // edge after the count reaches STAGES.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         rdy_q <= 1'b0;
      end else if (bus.flush) begin
         cnt_q <= '0;
         rdy_q <= 1'b0;
      end else if (!bus.hold) begin
         if (cnt_q != FULL) begin
            cnt_q <= cnt_q + 1'b1;
         end
         rdy_q <= (cnt_q == FULL);
      end
   end

   assign bus.pipe_rdy = rdy_q;

   // ------------------------------------------------------------------------
   // Output mux: bypass is purely combinational, pipeline keeps running
   // ------------------------------------------------------------------------
   always_comb begin
      dout_pipe = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         dout_pipe[c*W +: W] = d_q[LAST][c];
      end
   end

   assign bus.dout    = bus.byp ? bus.din    : dout_pipe;
   assign bus.vld_out = bus.byp ? bus.vld_in : v_q[LAST];

   // ------------------------------------------------------------------------
   // Optional parity tracking
   // ------------------------------------------------------------------------
`ifdef BW_IO_DDR_RPTR_PAR_EN
   logic [NCH-1:0] p_q [STAGES];
   logic [NCH-1:0] perr_q;
   logic [NCH-1:0] par_bad;

   // parity bits follow exactly the same gating as the data they cover
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            p_q[k] <= '0;
         end
      end else if (!bus.flush && !bus.hold) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            if (bus.vld_in[c]) begin
               p_q[0][c] <= bus.din_par[c];
            end
         end
         for (int unsigned k = 1; k < STAGES; k++) begin
            for (int unsigned c = 0; c < NCH; c++) begin
               if (v_q[k-1][c]) begin
                  p_q[k][c] <= p_q[k-1][c];
               end
            end
         end
      end
   end

   always_comb begin
      par_bad = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         par_bad[c] = (^d_q[LAST][c]) ^ p_q[LAST][c];
      end
   end

   // checked only on pipelined output beats; bypass traffic is not checked
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perr_q <= '0;
      end else if (bus.flush) begin
         perr_q <= '0;
      end else if (!bus.hold) begin
         perr_q <= perr_q | (v_q[LAST] & par_bad & {NCH{~bus.byp}});
      end
   end

   assign bus.perr = perr_q;
`else
   logic unused_din_par;
   assign unused_din_par = ^bus.din_par;
   assign bus.perr       = '0;
`endif

endmodule
